// File: rtl/regfile_writeback_pkg.sv
// Shared types and constants for the register-file writeback stage.
// The writeback entry layout is shared so a second writeback port can reuse it.
package regfile_writeback_pkg;

    localparam int unsigned WB_WIDTH = 64;
    localparam int unsigned WB_DEPTH = 5;
    localparam int unsigned WB_CNT_W = 32;

    localparam logic [WB_DEPTH-1:0] REG_ZERO = 5'h0;

    typedef struct packed {
        logic                vld;
        logic [WB_DEPTH-1:0] rd;
        logic [WB_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_LD,
        SRC_ALU
    } wb_src_e;

    // True when an in-flight entry targets the given read address (x0 never matches).
    function automatic logic wb_hit(
        input logic                vld,
        input logic [WB_DEPTH-1:0] rd,
        input logic [WB_DEPTH-1:0] rs
    );
        return vld && (rd == rs) && (rs != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, two lookup ports.
// A register being retired this cycle reports not-busy because the bypass serves it.
module regfile_scoreboard
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned DEPTH = WB_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [DEPTH-1:0] set_rd,
    input  logic             clr_en,
    input  logic [DEPTH-1:0] clr_rd,
    input  logic [DEPTH-1:0] rs_a,
    input  logic [DEPTH-1:0] rs_b,
    output logic             busy_a,
    output logic             busy_b
);

    localparam int unsigned NREG = 1 << DEPTH;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

    // Clear first, then set, so a newer producer issued in the retire cycle stays outstanding.
    always_comb begin
        pending_nxt = pending;
        if (clr_en) begin
            pending_nxt[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            pending_nxt[set_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_comb begin
        busy_a = pending[rs_a] & ~(clr_en & (clr_rd == rs_a));
        busy_b = pending[rs_b] & ~(clr_en & (clr_rd == rs_b));
    end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage for the 32-entry register file: load/ALU arbitration, one-entry
// stage register, write port, operand bypass, pending-write scoreboard and retire counter.
module regfile_writeback
    import regfile_writeback_pkg::*;
#(
    parameter int unsigned WIDTH = WB_WIDTH,
    parameter int unsigned DEPTH = WB_DEPTH,
    parameter int unsigned CNT_W = WB_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             ld_valid_i,
    input  logic [DEPTH-1:0] ld_rd_i,
    input  logic [WIDTH-1:0] ld_data_i,
    output logic             ld_ready_o,
    input  logic             alu_valid_i,
    input  logic [DEPTH-1:0] alu_rd_i,
    input  logic [WIDTH-1:0] alu_data_i,
    output logic             alu_ready_o,
    input  logic             iss_valid_i,
    input  logic [DEPTH-1:0] iss_rd_i,
    input  logic [DEPTH-1:0] rs_a_i,
    input  logic [DEPTH-1:0] rs_b_i,
    input  logic [WIDTH-1:0] rf_data_a_i,
    input  logic [WIDTH-1:0] rf_data_b_i,
    output logic [WIDTH-1:0] fwd_a_o,
    output logic [WIDTH-1:0] fwd_b_o,
    output logic             busy_a_o,
    output logic             busy_b_o,
    output logic             wr_en_o,
    output logic [DEPTH-1:0] addr_wr_o,
    output logic [WIDTH-1:0] data_wr_o,
    output logic [CNT_W-1:0] wr_count_o
);

    wb_entry_t        wb;
    wb_src_e          src;
    logic             wr_en;
    logic [CNT_W-1:0] count;

    // Load path has fixed priority; the ALU is only accepted when no load is offered.
    assign ld_ready_o  = rst_ni;
    assign alu_ready_o = rst_ni & ~ld_valid_i;

    always_comb begin
        src = SRC_NONE;
        if (ld_valid_i && ld_ready_o) begin
            src = SRC_LD;
        end else if (alu_valid_i && alu_ready_o) begin
            src = SRC_ALU;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb <= '0;
        end else begin
            case (src)
                SRC_LD: begin
                    wb.vld  <= 1'b1;
                    wb.rd   <= ld_rd_i;
                    wb.data <= ld_data_i;
                end
                SRC_ALU: begin
                    wb.vld  <= 1'b1;
                    wb.rd   <= alu_rd_i;
                    wb.data <= alu_data_i;
                end
                default: begin
                    wb.vld <= 1'b0;
                end
            endcase
        end
    end

    // Reset gates the write so a held result is dropped rather than committed on the reset edge.
    assign wr_en     = rst_ni & wb.vld & (wb.rd != REG_ZERO);
    assign wr_en_o   = wr_en;
    assign addr_wr_o = wb.rd;
    assign data_wr_o = wb.data;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (wr_en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign wr_count_o = count;

    // The register file returns the old value until the edge, so the stage entry wins.
    always_comb begin
        fwd_a_o = wb_hit(wb.vld, wb.rd, rs_a_i) ? wb.data : rf_data_a_i;
        fwd_b_o = wb_hit(wb.vld, wb.rd, rs_b_i) ? wb.data : rf_data_b_i;
    end

    regfile_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .set_en(iss_valid_i),
        .set_rd(iss_rd_i),
        .clr_en(wr_en),
        .clr_rd(wb.rd),
        .rs_a  (rs_a_i),
        .rs_b  (rs_b_i),
        .busy_a(busy_a_o),
        .busy_b(busy_b_o)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic against
// a cycle-level reference model of the writeback stage, scoreboard and counter.
`timescale 1ns/100ps
module tb_regfile_writeback;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        ld_valid_i, alu_valid_i, iss_valid_i;
    logic [4:0]  ld_rd_i, alu_rd_i, iss_rd_i, rs_a_i, rs_b_i;
    logic [63:0] ld_data_i, alu_data_i, rf_data_a_i, rf_data_b_i;
    logic        ld_ready_o, alu_ready_o, busy_a_o, busy_b_o, wr_en_o;
    logic [63:0] fwd_a_o, fwd_b_o, data_wr_o;
    logic [4:0]  addr_wr_o;
    logic [31:0] wr_count_o;

    regfile_writeback #(
        .WIDTH(64),
        .DEPTH(5),
        .CNT_W(32)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ld_valid_i (ld_valid_i),
        .ld_rd_i    (ld_rd_i),
        .ld_data_i  (ld_data_i),
        .ld_ready_o (ld_ready_o),
        .alu_valid_i(alu_valid_i),
        .alu_rd_i   (alu_rd_i),
        .alu_data_i (alu_data_i),
        .alu_ready_o(alu_ready_o),
        .iss_valid_i(iss_valid_i),
        .iss_rd_i   (iss_rd_i),
        .rs_a_i     (rs_a_i),
        .rs_b_i     (rs_b_i),
        .rf_data_a_i(rf_data_a_i),
        .rf_data_b_i(rf_data_b_i),
        .fwd_a_o    (fwd_a_o),
        .fwd_b_o    (fwd_b_o),
        .busy_a_o   (busy_a_o),
        .busy_b_o   (busy_b_o),
        .wr_en_o    (wr_en_o),
        .addr_wr_o  (addr_wr_o),
        .data_wr_o  (data_wr_o),
        .wr_count_o (wr_count_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: the single in-flight result, the set of outstanding destinations, retire count.
    bit          m_vld;
    bit [4:0]    m_rd;
    bit [63:0]   m_data;
    bit          m_pend [32];
    bit [31:0]   m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_writes();
        return rst_ni && m_vld && (m_rd != 0);
    endfunction

    function automatic bit [63:0] model_fwd(input bit [4:0] rs, input bit [63:0] rf);
        if (m_vld && m_rd == rs && rs != 0) return m_data;
        return rf;
    endfunction

    function automatic bit model_busy(input bit [4:0] rs);
        return m_pend[rs] && !(model_writes() && m_rd == rs);
    endfunction

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit        n_vld;
        bit [4:0]  n_rd;
        bit [63:0] n_data;
        bit        n_pend [32];
        bit [31:0] n_cnt;
        @(negedge clk_i);
        check("ld_ready",  ld_ready_o,  rst_ni);
        check("alu_ready", alu_ready_o, rst_ni && !ld_valid_i);
        check("wr_en",     wr_en_o,     model_writes());
        check("addr_wr",   addr_wr_o,   m_rd);
        check("data_wr",   data_wr_o,   m_data);
        check("fwd_a",     fwd_a_o,     model_fwd(rs_a_i, rf_data_a_i));
        check("fwd_b",     fwd_b_o,     model_fwd(rs_b_i, rf_data_b_i));
        check("busy_a",    busy_a_o,    model_busy(rs_a_i));
        check("busy_b",    busy_b_o,    model_busy(rs_b_i));
        check("wr_count",  wr_count_o,  m_cnt);
        n_pend = m_pend;
        n_vld  = m_vld;
        n_rd   = m_rd;
        n_data = m_data;
        n_cnt  = m_cnt;
        if (!rst_ni) begin
            n_vld = 0; n_rd = 0; n_data = 0; n_cnt = 0;
            foreach (n_pend[i]) n_pend[i] = 0;
        end else begin
            if (model_writes()) begin
                n_pend[m_rd] = 0;
                n_cnt = m_cnt + 1;
            end
            if (iss_valid_i && iss_rd_i != 0) n_pend[iss_rd_i] = 1;
            if (ld_valid_i) begin
                n_vld = 1; n_rd = ld_rd_i; n_data = ld_data_i;
            end else if (alu_valid_i) begin
                n_vld = 1; n_rd = alu_rd_i; n_data = alu_data_i;
            end else begin
                n_vld = 0;
            end
        end
        @(posedge clk_i);
        m_vld = n_vld; m_rd = n_rd; m_data = n_data; m_pend = n_pend; m_cnt = n_cnt;
        #1;
    endtask

    // Walk every register through port A between edges and compare busy against the model.
    task automatic sweep_busy();
        logic [4:0] keep;
        keep = rs_a_i;
        for (int r = 0; r < 32; r++) begin
            rs_a_i = 5'(r);
            #0.1;
            check("busy_sweep", busy_a_o, model_busy(5'(r)));
        end
        rs_a_i = keep;
    endtask

    task automatic idle_inputs();
        ld_valid_i = 0; alu_valid_i = 0; iss_valid_i = 0;
    endtask

    initial begin
        m_vld = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
        rst_ni = 0;
        ld_valid_i = 1; ld_rd_i = 5; ld_data_i = 64'h55;
        alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
        iss_valid_i = 1; iss_rd_i = 6;
        rs_a_i = 0; rs_b_i = 0; rf_data_a_i = 0; rf_data_b_i = 0;

        // Reset held with a load offered: nothing may be written.
        step();
        check("rst_wr_en_1", wr_en_o, 1'b0);
        step();
        check("rst_wr_en_2", wr_en_o, 1'b0);
        rst_ni = 1;
        idle_inputs();
        step();
        check("rst_count", wr_count_o, 32'd0);
        sweep_busy();

        // Single load: accepted at edge N, written at edge N+1.
        ld_valid_i = 1; ld_rd_i = 5; ld_data_i = 64'hDEAD_BEEF;
        step();
        check("ld_wr_en", wr_en_o, 1'b1);
        check("ld_addr",  addr_wr_o, 5'd5);
        check("ld_data",  data_wr_o, 64'hDEAD_BEEF);
        idle_inputs();
        step();
        check("ld_count", wr_count_o, 32'd1);

        // Contention: load wins, ALU held and taken next cycle.
        ld_valid_i = 1; ld_rd_i = 3; ld_data_i = 64'h11;
        alu_valid_i = 1; alu_rd_i = 4; alu_data_i = 64'h22;
        #0.1;
        check("cont_alu_ready", alu_ready_o, 1'b0);
        step();
        check("cont_first", addr_wr_o, 5'd3);
        ld_valid_i = 0;
        step();
        check("cont_second_addr", addr_wr_o, 5'd4);
        check("cont_second_data", data_wr_o, 64'h22);
        idle_inputs();
        step();

        // x0 result: occupies the stage but never writes or counts.
        alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 64'hFF;
        rs_a_i = 0; rf_data_a_i = 0;
        step();
        check("x0_wr_en", wr_en_o, 1'b0);
        check("x0_fwd_a", fwd_a_o, 64'h0);
        idle_inputs();
        step();
        check("x0_count", wr_count_o, 32'd3);

        // Bypass on port A, passthrough on port B.
        ld_valid_i = 1; ld_rd_i = 7; ld_data_i = 64'h1234;
        step();
        rs_a_i = 7; rf_data_a_i = 0; rs_b_i = 8; rf_data_b_i = 64'hABCD;
        #0.1;
        check("byp_a", fwd_a_o, 64'h1234);
        check("byp_b", fwd_b_o, 64'hABCD);
        idle_inputs();
        step();

        // Scoreboard: busy until the write cycle, not busy during it.
        iss_valid_i = 1; iss_rd_i = 9;
        step();
        iss_valid_i = 0; rs_a_i = 9;
        #0.1;
        check("sb_busy", busy_a_o, 1'b1);
        ld_valid_i = 1; ld_rd_i = 9; ld_data_i = 64'h99;
        step();
        ld_valid_i = 0;
        #0.1;
        check("sb_write_cycle", busy_a_o, 1'b0);
        step();
        check("sb_cleared", busy_a_o, 1'b0);

        // Reissue in the retire cycle: the newer producer keeps the bit set.
        iss_valid_i = 1; iss_rd_i = 9;
        step();
        iss_valid_i = 0;
        ld_valid_i = 1; ld_rd_i = 9; ld_data_i = 64'h77;
        step();
        ld_valid_i = 0;
        iss_valid_i = 1; iss_rd_i = 9;
        step();
        iss_valid_i = 0;
        #0.1;
        check("sb_set_wins", busy_a_o, 1'b1);

        // Randomized traffic, occasional mid-operation reset.
        for (int c = 0; c < 600; c++) begin
            rst_ni      = ($urandom_range(0, 59) != 0);
            ld_valid_i  = ($urandom_range(0, 2) == 0);
            ld_rd_i     = 5'($urandom_range(0, 7));
            ld_data_i   = {$urandom, $urandom};
            alu_valid_i = ($urandom_range(0, 1) == 0);
            alu_rd_i    = 5'($urandom_range(0, 7));
            alu_data_i  = {$urandom, $urandom};
            iss_valid_i = ($urandom_range(0, 2) == 0);
            iss_rd_i    = 5'($urandom_range(0, 7));
            rs_a_i      = 5'($urandom_range(0, 7));
            rs_b_i      = 5'($urandom_range(0, 7));
            rf_data_a_i = {$urandom, $urandom};
            rf_data_b_i = {$urandom, $urandom};
            step();
            if (c % 40 == 39) sweep_busy();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side companion to the 64-bit, 32-entry register file in the segmented core.
- Accepts results from the load path and the ALU path through valid/ready handshakes and holds one result in a writeback stage register.
- Drives the register file write port and forwards in-flight writeback data onto both read ports.
- Keeps a pending-write scoreboard so hazard logic can stall readers of registers not yet written.

Parameters:
- WIDTH, 64, data width (matches register file).
- DEPTH, 5, register address width; 2**DEPTH registers.
- CNT_W, 32, width of retired-write counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous, active-low reset.
- ld_valid_i  in  1  load result valid.
- ld_rd_i  in  DEPTH  load destination register.
- ld_data_i  in  WIDTH  load data.
- ld_ready_o  out  1  load result accepted.
- alu_valid_i  in  1  ALU result valid.
- alu_rd_i  in  DEPTH  ALU destination register.
- alu_data_i  in  WIDTH  ALU data.
- alu_ready_o  out  1  ALU result accepted.
- iss_valid_i  in  1  instruction with destination issued.
- iss_rd_i  in  DEPTH  issued destination register.
- rs_a_i  in  DEPTH  read address A, mirrored from register file port A.
- rs_b_i  in  DEPTH  read address B, mirrored from register file port B.
- rf_data_a_i  in  WIDTH  register file data A.
- rf_data_b_i  in  WIDTH  register file data B.
- fwd_a_o  out  WIDTH  bypassed operand A.
- fwd_b_o  out  WIDTH  bypassed operand B.
- busy_a_o  out  1  rs_a has a pending write.
- busy_b_o  out  1  rs_b has a pending write.
- wr_en_o  out  1  register file write enable.
- addr_wr_o  out  DEPTH  register file write address.
- data_wr_o  out  WIDTH  register file write data.
- wr_count_o  out  CNT_W  retired writes (wr_en_o cycles).

Behaviour:
- Reset state: wb_vld, wb_rd, wb_data, pending[31:0], wr_count all 0.
- Reset outputs: wr_en_o=0, addr_wr_o=0, data_wr_o=0, busy_*=0, wr_count_o=0.
- While rst_ni=0, wr_en_o is forced to 0 combinationally, so no write occurs on the reset edge.
- Arbitration: load has fixed priority.
  - ld_ready_o=rst_ni.
  - alu_ready_o=rst_ni & ~ld_valid_i.
- Transfer occurs when valid & ready. At most one transfer per cycle.
- Stage register:
  - On a transfer: wb_vld<=1; wb_rd/wb_data <= winner's rd/data.
  - With no transfer: wb_vld<=0.
  - Throughput is 1 per cycle with no bubbles.
- Write port:
  - wr_en_o = rst_ni & wb_vld & (wb_rd!=0).
  - addr_wr_o=wb_rd; data_wr_o=wb_data.
  - Latency: result accepted at edge N, written into the register file at edge N+1.
- x0 handling: a result with rd=0 is accepted and occupies the stage, but never asserts wr_en_o and is not counted.
- Bypass (combinational):
  - fwd_a_o = (wb_vld & wb_rd==rs_a_i & rs_a_i!=0) ? wb_data : rf_data_a_i.
  - fwd_b_o is identical on port B.
  - This covers the same-cycle write/read case, because the register file returns the old value until the edge.
- Scoreboard:
  - On iss_valid_i with iss_rd_i!=0: pending[iss_rd_i]<=1.
  - When wr_en_o is asserted: pending[wb_rd]<=0.
  - Same register set and cleared in one cycle: set wins (newer producer outstanding).
  - pending[0] is constant 0.
  - busy_a_o = pending[rs_a_i] & ~(wr_en_o & wb_rd==rs_a_i); port B identical. A register being written this cycle is served by the bypass, so it is not busy.
- Counter: wr_count increments by 1 on each wr_en_o cycle and wraps at 2**CNT_W.
- Reset mid-operation: a held result is discarded (not written), the scoreboard is cleared, and the counter is zeroed. Producers must reissue.

Decomposition:
- Shared package:
  - WIDTH/DEPTH defaults.
  - REG_ZERO constant (5'h0).
  - A wb_entry typedef {vld, rd, data} used by the stage register and any future second writeback port.
- One natural sub-module: regfile_scoreboard (pending bits, set/clear priority, busy lookup, two read ports).

Test Plan:
- Reset: hold rst_ni=0 with ld_valid_i=1 for 2 cycles -> wr_en_o=0 throughout; after release pending=0, wr_count_o=0.
- Single load: ld rd=5, data=64'hDEAD_BEEF accepted at edge N -> at edge N+1 wr_en_o=1, addr=5, data=DEAD_BEEF; wr_count_o=1.
- Contention: ld (rd=3, 0x11) and alu (rd=4, 0x22) valid together -> alu_ready_o=0, load written first; ALU held, accepted next cycle, written one cycle later.
- x0: alu rd=0, data=0xFF -> wr_en_o stays 0; with rs_a_i=0 and rf_data_a_i=0, fwd_a_o=0; wr_count unchanged.
- Bypass: stage holds rd=7/0x1234, rs_a_i=7, rf_data_a_i=0x0 -> fwd_a_o=0x1234; rs_b_i=8 -> fwd_b_o=rf_data_b_i.
- Scoreboard:
  - Issue rd=9 -> busy_a_o=1 for rs_a_i=9 until the write cycle, where busy_a_o=0.
  - Issue rd=9 in the same cycle as its write -> pending[9] remains 1 after the edge.
